// File: rtl/cr16_datapath_sequencer.sv
// Purpose: sequences a CR16-style register-file datapath to fill r0..r(count-1)
//          with Fibonacci, arithmetic or doubling series using ADD writes.
// Latency: free-run O_DONE is high count+2 cycles after START is sampled.
//          Step mode waits for I_ADVANCE before each write.
// Ports:   I_CLK/I_NRESET; run control I_START, I_MODE, I_SEED_A/B, I_COUNT,
//          I_STEP, I_HALT_ON_OVF, I_ADVANCE; ALU carry I_CARRY_FLAG in;
//          O_REG_ENABLE, O_READ_A/B_SEL, O_IMMEDIATE, O_IMM_SEL, O_OPCODE and
//          O_DP_NRESET drive the datapath; O_BUSY/O_DONE/O_OVERFLOW/O_INDEX
//          report status. Every output comes from a flop.
module cr16_datapath_sequencer #(
  parameter int NUM_REGS   = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  I_CLK,
  input  logic                  I_NRESET,
  input  logic                  I_START,
  input  logic [1:0]            I_MODE,
  input  logic [DATA_WIDTH-1:0] I_SEED_A,
  input  logic [DATA_WIDTH-1:0] I_SEED_B,
  input  logic [4:0]            I_COUNT,
  input  logic                  I_STEP,
  input  logic                  I_HALT_ON_OVF,
  input  logic                  I_ADVANCE,
  input  logic                  I_CARRY_FLAG,
  output logic [NUM_REGS-1:0]   O_REG_ENABLE,
  output logic [3:0]            O_READ_A_SEL,
  output logic [3:0]            O_READ_B_SEL,
  output logic [DATA_WIDTH-1:0] O_IMMEDIATE,
  output logic                  O_IMM_SEL,
  output logic [3:0]            O_OPCODE,
  output logic                  O_DP_NRESET,
  output logic                  O_BUSY,
  output logic                  O_DONE,
  output logic                  O_OVERFLOW,
  output logic [3:0]            O_INDEX
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SEED0, S_SEED1, S_COMPUTE, S_DONE
  } state_t;

  localparam logic [1:0] MODE_FIB   = 2'd0;
  localparam logic [1:0] MODE_ARITH = 2'd1;
  localparam logic [1:0] MODE_DBL   = 2'd2;
  localparam logic [3:0] OP_ADD     = 4'd1;

  // Control state
  state_t                state_q, state_d;
  logic                  wr_phase_q, wr_phase_d;   // 0 = WAIT, 1 = WRITE
  logic [3:0]            idx_q, idx_d;
  logic [1:0]            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] seed_a_q, seed_a_d, seed_b_q, seed_b_d;
  logic                  step_q, step_d, halt_q, halt_d;
  logic [4:0]            count_q, count_d;
  logic                  overflow_q, overflow_d;

  // Output flops
  logic [NUM_REGS-1:0]   reg_enable_q, reg_enable_d;
  logic [3:0]            read_a_sel_q, read_a_sel_d, read_b_sel_q, read_b_sel_d;
  logic [DATA_WIDTH-1:0] immediate_q, immediate_d;
  logic                  imm_sel_q, imm_sel_d;
  logic [3:0]            opcode_q, opcode_d;
  logic                  dp_nreset_q, dp_nreset_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic [3:0]            index_q, index_d;

  logic                  is_write_q, is_write_d;

  assign is_write_q = (state_q == S_SEED0) || (state_q == S_SEED1) || (state_q == S_COMPUTE);
  assign is_write_d = (state_d == S_SEED0) || (state_d == S_SEED1) || (state_d == S_COMPUTE);

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    wr_phase_d = wr_phase_q;
    idx_d      = idx_q;
    mode_d     = mode_q;
    seed_a_d   = seed_a_q;
    seed_b_d   = seed_b_q;
    step_d     = step_q;
    halt_d     = halt_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (I_START) begin
          state_d    = S_CLEAR;
          mode_d     = (I_MODE == 2'd3) ? MODE_FIB : I_MODE;
          seed_a_d   = I_SEED_A;
          seed_b_d   = I_SEED_B;
          step_d     = I_STEP;
          halt_d     = I_HALT_ON_OVF;
          overflow_d = 1'b0;
          if (I_COUNT < 5'd2)                 count_d = 5'd2;
          else if (I_COUNT > 5'(NUM_REGS))    count_d = 5'(NUM_REGS);
          else                                count_d = I_COUNT;
        end
      end
      S_CLEAR: begin
        state_d    = S_SEED0;
        idx_d      = 4'd0;
        wr_phase_d = !step_q;
      end
      S_SEED0, S_SEED1, S_COMPUTE: begin
        if (!wr_phase_q) begin
          if (I_ADVANCE) wr_phase_d = 1'b1;
        end else begin
          // Carry belongs to the write completing on this edge.
          wr_phase_d = !step_q;
          if (I_CARRY_FLAG) overflow_d = 1'b1;
          if (I_CARRY_FLAG && halt_q) begin
            state_d = S_DONE;
          end else if (state_q == S_SEED0) begin
            state_d = S_SEED1;
            idx_d   = 4'd1;
          end else if (({1'b0, idx_q} + 5'd1) == count_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_COMPUTE;
            idx_d   = idx_q + 4'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they appear in the same cycle as
  // the state they describe, straight from flops.
  always_comb begin
    reg_enable_d = '0;
    read_a_sel_d = 4'd0;
    read_b_sel_d = 4'd0;
    immediate_d  = '0;
    imm_sel_d    = 1'b0;
    opcode_d     = 4'd0;
    dp_nreset_d  = 1'b1;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    index_d      = 4'd0;
    if (state_d == S_CLEAR) begin
      busy_d      = 1'b1;
      dp_nreset_d = 1'b0;
    end else if (state_d == S_DONE) begin
      busy_d = 1'b1;
      done_d = 1'b1;
    end else if (is_write_d) begin
      busy_d   = 1'b1;
      opcode_d = OP_ADD;
      index_d  = idx_d;
      if (wr_phase_d) reg_enable_d = NUM_REGS'(1) << idx_d;
      if (state_d == S_SEED0) begin
        imm_sel_d   = 1'b1;
        immediate_d = seed_a_d;
      end else if (state_d == S_SEED1) begin
        if (mode_d == MODE_ARITH) begin
          imm_sel_d   = 1'b1;
          immediate_d = seed_b_d;
        end else if (mode_d != MODE_DBL) begin
          // r1 still reads 0 after CLEAR, so r1 = SEED_B.
          read_a_sel_d = 4'd1;
          imm_sel_d    = 1'b1;
          immediate_d  = seed_b_d;
        end
      end else begin
        if (mode_d == MODE_ARITH) begin
          read_a_sel_d = idx_d - 4'd1;
          imm_sel_d    = 1'b1;
          immediate_d  = seed_b_d;
        end else if (mode_d == MODE_DBL) begin
          read_a_sel_d = idx_d - 4'd1;
          read_b_sel_d = idx_d - 4'd1;
        end else begin
          read_a_sel_d = idx_d - 4'd2;
          read_b_sel_d = idx_d - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state_q      <= S_IDLE;
      wr_phase_q   <= 1'b0;
      idx_q        <= 4'd0;
      mode_q       <= 2'd0;
      seed_a_q     <= '0;
      seed_b_q     <= '0;
      step_q       <= 1'b0;
      halt_q       <= 1'b0;
      count_q      <= 5'd2;
      overflow_q   <= 1'b0;
      reg_enable_q <= '0;
      read_a_sel_q <= 4'd0;
      read_b_sel_q <= 4'd0;
      immediate_q  <= '0;
      imm_sel_q    <= 1'b0;
      opcode_q     <= 4'd0;
      dp_nreset_q  <= 1'b0;   // datapath held in reset alongside us
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      index_q      <= 4'd0;
    end else begin
      state_q      <= state_d;
      wr_phase_q   <= wr_phase_d;
      idx_q        <= idx_d;
      mode_q       <= mode_d;
      seed_a_q     <= seed_a_d;
      seed_b_q     <= seed_b_d;
      step_q       <= step_d;
      halt_q       <= halt_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      reg_enable_q <= reg_enable_d;
      read_a_sel_q <= read_a_sel_d;
      read_b_sel_q <= read_b_sel_d;
      immediate_q  <= immediate_d;
      imm_sel_q    <= imm_sel_d;
      opcode_q     <= opcode_d;
      dp_nreset_q  <= dp_nreset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      index_q      <= index_d;
    end
  end

  assign O_REG_ENABLE = reg_enable_q;
  assign O_READ_A_SEL = read_a_sel_q;
  assign O_READ_B_SEL = read_b_sel_q;
  assign O_IMMEDIATE  = immediate_q;
  assign O_IMM_SEL    = imm_sel_q;
  assign O_OPCODE     = opcode_q;
  assign O_DP_NRESET  = dp_nreset_q;
  assign O_BUSY       = busy_q;
  assign O_DONE       = done_q;
  assign O_OVERFLOW   = overflow_q;
  assign O_INDEX      = index_q;

  // is_write_q documents the current-state decode used by the phase logic.
  logic unused_ok;
  assign unused_ok = is_write_q;

endmodule

// File: tb/tb_cr16_datapath_sequencer.sv
// Bench for cr16_datapath_sequencer: models the 16x16 register file and
// adder (carry fed back combinationally), runs a vector table of complete
// runs plus hand sequences for step mode and reset during a run.
module tb_cr16_datapath_sequencer;

  logic        I_CLK = 1'b0;
  logic        I_NRESET;
  logic        I_START;
  logic [1:0]  I_MODE;
  logic [15:0] I_SEED_A, I_SEED_B;
  logic [4:0]  I_COUNT;
  logic        I_STEP, I_HALT_ON_OVF, I_ADVANCE;
  logic        I_CARRY_FLAG;
  logic [15:0] O_REG_ENABLE;
  logic [3:0]  O_READ_A_SEL, O_READ_B_SEL;
  logic [15:0] O_IMMEDIATE;
  logic        O_IMM_SEL;
  logic [3:0]  O_OPCODE;
  logic        O_DP_NRESET, O_BUSY, O_DONE, O_OVERFLOW;
  logic [3:0]  O_INDEX;

  cr16_datapath_sequencer #(.NUM_REGS(16), .DATA_WIDTH(16)) dut (
    .I_CLK(I_CLK), .I_NRESET(I_NRESET), .I_START(I_START), .I_MODE(I_MODE),
    .I_SEED_A(I_SEED_A), .I_SEED_B(I_SEED_B), .I_COUNT(I_COUNT),
    .I_STEP(I_STEP), .I_HALT_ON_OVF(I_HALT_ON_OVF), .I_ADVANCE(I_ADVANCE),
    .I_CARRY_FLAG(I_CARRY_FLAG), .O_REG_ENABLE(O_REG_ENABLE),
    .O_READ_A_SEL(O_READ_A_SEL), .O_READ_B_SEL(O_READ_B_SEL),
    .O_IMMEDIATE(O_IMMEDIATE), .O_IMM_SEL(O_IMM_SEL), .O_OPCODE(O_OPCODE),
    .O_DP_NRESET(O_DP_NRESET), .O_BUSY(O_BUSY), .O_DONE(O_DONE),
    .O_OVERFLOW(O_OVERFLOW), .O_INDEX(O_INDEX)
  );

  always #5 I_CLK = ~I_CLK;

  // Datapath model: register file plus 17-bit adder.
  logic [15:0] rf [16];
  logic [16:0] sum;
  int          en_cnt = 0;
  assign sum          = {1'b0, rf[O_READ_A_SEL]} + {1'b0, (O_IMM_SEL ? O_IMMEDIATE : rf[O_READ_B_SEL])};
  assign I_CARRY_FLAG = sum[16];

  always @(posedge I_CLK) begin
    if (!O_DP_NRESET) begin
      for (int i = 0; i < 16; i++) rf[i] <= 16'h0;
    end else if (O_REG_ENABLE != 16'h0) begin
      for (int i = 0; i < 16; i++) if (O_REG_ENABLE[i]) rf[i] <= sum[15:0];
      en_cnt <= en_cnt + 1;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]        mode;
    logic [15:0]       a, b;
    logic [4:0]        count;
    logic              step, halt;
    logic [15:0][15:0] exp_rf;
    logic              exp_ovf;
    int                exp_done;
    int                exp_wr;
  } vec_t;

  function automatic logic [15:0][15:0] rf8(input logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7);
    return {128'h0, r7, r6, r5, r4, r3, r2, r1, r0};
  endfunction

  task automatic run_vec(input int id, input vec_t v);
    int cyc;
    int base;
    base          = en_cnt;
    I_MODE        = v.mode;
    I_SEED_A      = v.a;
    I_SEED_B      = v.b;
    I_COUNT       = v.count;
    I_STEP        = v.step;
    I_HALT_ON_OVF = v.halt;
    I_ADVANCE     = v.step;
    I_START       = 1'b1;
    @(posedge I_CLK); #1;
    I_START = 1'b0;
    cyc = 1;
    chk($sformatf("v%0d clear_busy", id), 32'(O_BUSY), 32'd1);
    chk($sformatf("v%0d clear_dp_nreset", id), 32'(O_DP_NRESET), 32'd0);
    while (!O_DONE && cyc < 60) begin
      @(posedge I_CLK); #1;
      cyc++;
    end
    chk($sformatf("v%0d done_cycle", id), 32'(cyc), 32'(v.exp_done));
    chk($sformatf("v%0d overflow", id), 32'(O_OVERFLOW), 32'(v.exp_ovf));
    chk($sformatf("v%0d write_count", id), 32'(en_cnt - base), 32'(v.exp_wr));
    for (int i = 0; i < 16; i++)
      chk($sformatf("v%0d r%0d", id, i), 32'(rf[i]), 32'(v.exp_rf[i]));
    @(posedge I_CLK); #1;
    chk($sformatf("v%0d idle_busy", id), 32'(O_BUSY), 32'd0);
    chk($sformatf("v%0d idle_done", id), 32'(O_DONE), 32'd0);
    I_ADVANCE = 1'b0;
  endtask

  vec_t vt [9];

  initial begin
    int base;
    logic [15:0] exp_en;
    vt[0] = '{2'd0, 16'd1, 16'd1, 5'd8, 1'b0, 1'b0, rf8(1, 1, 2, 3, 5, 8, 13, 21), 1'b0, 10, 8};
    vt[1] = '{2'd1, 16'd5, 16'd3, 5'd4, 1'b0, 1'b0, rf8(5, 8, 11, 14, 0, 0, 0, 0), 1'b0, 6, 4};
    vt[2] = '{2'd2, 16'd1, 16'd0, 5'd16, 1'b0, 1'b0, '0, 1'b0, 18, 16};
    for (int i = 0; i < 16; i++) vt[2].exp_rf[i] = 16'(32'd1 << i);
    vt[3] = vt[2];
    vt[3].count = 5'd17;
    vt[4] = '{2'd2, 16'd1, 16'd0, 5'd1, 1'b0, 1'b0, rf8(1, 2, 0, 0, 0, 0, 0, 0), 1'b0, 4, 2};
    vt[5] = '{2'd0, 16'h8000, 16'h8000, 5'd6, 1'b0, 1'b1,
              rf8(16'h8000, 16'h8000, 0, 0, 0, 0, 0, 0), 1'b1, 5, 3};
    vt[6] = '{2'd0, 16'h8000, 16'h8000, 5'd4, 1'b0, 1'b0,
              rf8(16'h8000, 16'h8000, 0, 16'h8000, 0, 0, 0, 0), 1'b1, 6, 4};
    vt[7] = '{2'd3, 16'd2, 16'd3, 5'd5, 1'b0, 1'b0, rf8(2, 3, 5, 8, 13, 0, 0, 0), 1'b0, 7, 5};
    vt[8] = '{2'd1, 16'd5, 16'd3, 5'd3, 1'b1, 1'b0, rf8(5, 8, 11, 0, 0, 0, 0, 0), 1'b0, 8, 3};

    I_NRESET = 1'b0; I_START = 1'b0; I_MODE = 2'd0; I_SEED_A = 16'h0; I_SEED_B = 16'h0;
    I_COUNT = 5'd0; I_STEP = 1'b0; I_HALT_ON_OVF = 1'b0; I_ADVANCE = 1'b0;
    #3;
    chk("rst_enable", 32'(O_REG_ENABLE), 32'h0);
    chk("rst_busy", 32'(O_BUSY), 32'd0);
    chk("rst_done", 32'(O_DONE), 32'd0);
    chk("rst_ovf", 32'(O_OVERFLOW), 32'd0);
    chk("rst_index", 32'(O_INDEX), 32'd0);
    chk("rst_dp_nreset", 32'(O_DP_NRESET), 32'd0);
    @(posedge I_CLK); @(posedge I_CLK); #1;
    I_NRESET = 1'b1;
    @(posedge I_CLK); #1;
    chk("idle_dp_nreset", 32'(O_DP_NRESET), 32'd1);
    chk("idle_opcode", 32'(O_OPCODE), 32'd0);

    for (int v = 0; v < 9; v++) run_vec(v, vt[v]);

    // Step mode with isolated advance pulses at cycles 5, 9 and 20.
    base = en_cnt;
    I_MODE = 2'd1; I_SEED_A = 16'd5; I_SEED_B = 16'd3; I_COUNT = 5'd3;
    I_STEP = 1'b1; I_HALT_ON_OVF = 1'b0; I_ADVANCE = 1'b0; I_START = 1'b1;
    @(posedge I_CLK); #1;
    I_START = 1'b0;
    for (int c = 1; c <= 23; c++) begin
      exp_en = (c == 6) ? 16'h1 : (c == 10) ? 16'h2 : (c == 21) ? 16'h4 : 16'h0;
      chk($sformatf("step c%0d enable", c), 32'(O_REG_ENABLE), 32'(exp_en));
      if (c == 7) chk("step wait index", 32'(O_INDEX), 32'd1);
      if (c == 22) chk("step done", 32'(O_DONE), 32'd1);
      I_ADVANCE = (c == 5 || c == 9 || c == 20);
      @(posedge I_CLK); #1;
    end
    I_ADVANCE = 1'b0;
    chk("step writes", 32'(en_cnt - base), 32'd3);
    chk("step r2", 32'(rf[2]), 32'd11);

    // 8-term run: mid-run START (with changed mode) ignored, reset during r4 write.
    base = en_cnt;
    I_MODE = 2'd0; I_SEED_A = 16'd1; I_SEED_B = 16'd1; I_COUNT = 5'd8;
    I_STEP = 1'b0; I_START = 1'b1;
    @(posedge I_CLK); #1;
    I_START = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 3) begin I_START = 1'b1; I_MODE = 2'd1; I_SEED_B = 16'd9; end
      if (c == 4) I_START = 1'b0;
      @(posedge I_CLK); #1;
    end
    chk("rr r4 enable", 32'(O_REG_ENABLE), 32'h10);
    chk("rr r4 index", 32'(O_INDEX), 32'd4);
    chk("rr r2 ignores start", 32'(rf[2]), 32'd2);
    chk("rr r3", 32'(rf[3]), 32'd3);
    I_NRESET = 1'b0;
    #1;
    chk("rr async enable", 32'(O_REG_ENABLE), 32'h0);
    chk("rr async busy", 32'(O_BUSY), 32'd0);
    chk("rr async index", 32'(O_INDEX), 32'd0);
    chk("rr async dp_nreset", 32'(O_DP_NRESET), 32'd0);
    @(posedge I_CLK); @(posedge I_CLK); #1;
    chk("rr writes", 32'(en_cnt - base), 32'd4);
    I_NRESET = 1'b1; I_MODE = 2'd0; I_SEED_B = 16'd1;
    @(posedge I_CLK); #1;
    chk("rr post busy", 32'(O_BUSY), 32'd0);
    chk("rr post enable", 32'(O_REG_ENABLE), 32'h0);
    chk("rr post dp_nreset", 32'(O_DP_NRESET), 32'd1);
    run_vec(9, vt[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
